// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, default widths, NOP.
package if_pkg;
   localparam int ADDR_W_DEF   = 32;
   localparam int WORD_W_DEF   = 16;
   localparam int LONG_BIT_DEF = 15;
   localparam logic [31:0] NOP = 32'h0;

   typedef enum logic [1:0] {FETCH, WORD0, WORD1, PEND} state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, idle non-stalled cycles insert a bubble.
module if_id_reg
   import if_pkg::*;
#(
   parameter int IW = 2 * WORD_W_DEF,
   parameter int AW = ADDR_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic          stall_i,
   input  logic          flush_i,
   input  logic [IW-1:0] instr_i,
   input  logic [AW-1:0] pc_i,
   output logic [IW-1:0] instr_o,
   output logic [AW-1:0] pc_o,
   output logic          valid_o
);
   logic [IW-1:0] instr_q;
   logic [AW-1:0] pc_q;
   logic          valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (flush_i) begin
         instr_q <= IW'(NOP);
         valid_q <= 1'b0;
      end else if (!stall_i) begin
         // pc and instr are kept across bubbles; only valid drops
         valid_q <= load_i;
         if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
         end
      end
   end

   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign valid_o = valid_q;
endmodule

// File: rtl/if_fetch_unit.sv
// Fetch FSM: reads one or two 16-bit words per instruction and hands the result to the IF/ID register.
module if_fetch_unit
   import if_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int WORD_W   = WORD_W_DEF,
   parameter int LONG_BIT = LONG_BIT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   pc_addr,
   input  logic                pc_valid,
   output logic                pc_hold,
   output logic                imem_rd_en,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic [WORD_W-1:0]   imem_data,
   input  logic                stall,
   input  logic                flush,
   output logic [2*WORD_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]   if_id_pc,
   output logic                if_id_valid
);
   state_e                state_q, state_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [ADDR_W-1:0]     cur_pc_q, cur_pc_d;
   logic [WORD_W-1:0]     lo_q, lo_d;
   logic [2*WORD_W-1:0]   buf_q, buf_d;
   logic [2*WORD_W-1:0]   instr;
   logic                  done;
   logic                  load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= FETCH;
         rd_en_q  <= 1'b0;
         addr_q   <= '0;
         cur_pc_q <= '0;
         lo_q     <= '0;
         buf_q    <= '0;
      end else begin
         state_q  <= state_d;
         rd_en_q  <= rd_en_d;
         addr_q   <= addr_d;
         cur_pc_q <= cur_pc_d;
         lo_q     <= lo_d;
         buf_q    <= buf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rd_en_d  = 1'b0;
      addr_d   = addr_q;
      cur_pc_d = cur_pc_q;
      lo_d     = lo_q;
      buf_d    = buf_q;
      instr    = buf_q;
      done     = 1'b0;
      load     = 1'b0;
      case (state_q)
         FETCH: begin
            if (pc_valid && !stall && !flush) begin
               rd_en_d  = 1'b1;
               addr_d   = pc_addr;
               cur_pc_d = pc_addr;
               state_d  = WORD0;
            end
         end
         WORD0: begin
            lo_d = imem_data;
            if (imem_data[LONG_BIT]) begin
               rd_en_d = 1'b1;
               addr_d  = cur_pc_q + ADDR_W'(1);
               state_d = WORD1;
            end else begin
               instr = {{WORD_W{1'b0}}, imem_data};
               done  = 1'b1;
            end
         end
         WORD1: begin
            instr = {lo_q, imem_data};
            done  = 1'b1;
         end
         PEND: begin
            if (!stall) begin
               load    = 1'b1;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
      // a completed instruction that decode can't take yet is parked in buf_q
      if (done) begin
         if (!stall) begin
            load    = 1'b1;
            state_d = FETCH;
         end else begin
            buf_d   = instr;
            state_d = PEND;
         end
      end
      if (flush) begin
         state_d = FETCH;
         rd_en_d = 1'b0;
         load    = 1'b0;
      end
   end

   assign pc_hold    = (state_q != FETCH) || stall;
   assign imem_rd_en = rd_en_q;
   assign imem_addr  = addr_q;

   if_id_reg #(.IW(2 * WORD_W), .AW(ADDR_W)) u_if_id (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .stall_i (stall),
      .flush_i (flush),
      .instr_i (instr),
      .pc_i    (cur_pc_q),
      .instr_o (if_id_instr),
      .pc_o    (if_id_pc),
      .valid_o (if_id_valid)
   );
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and randomized checks of if_fetch_unit against a transaction-level fetch model.
module tb_if_fetch_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_addr;
   logic        pc_valid;
   logic        pc_hold;
   logic        imem_rd_en;
   logic [31:0] imem_addr;
   logic [15:0] imem_data;
   logic        stall;
   logic        flush;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic        if_id_valid;

   logic [15:0] mem [256];
   int n_checks = 0;
   int n_err    = 0;

   // model: in-flight instruction is resolved at issue; only its timing is tracked
   logic        m_busy, m_pend;
   int          m_cnt;
   logic [31:0] m_instr, m_pc;
   logic        e_valid, e_rd;
   logic [31:0] e_instr, e_pc, e_addr;

   always #5 clk = ~clk;

   assign imem_data = imem_rd_en ? mem[imem_addr[7:0]] : 16'hFFFF;

   if_fetch_unit dut (
      .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_hold(pc_hold),
      .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_data(imem_data),
      .stall(stall), .flush(flush), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
      .if_id_valid(if_id_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_pend = 0; m_cnt = 0; m_instr = 0; m_pc = 0;
      e_valid = 0; e_rd = 0; e_instr = 0; e_pc = 0; e_addr = 0;
   endtask

   task automatic model_step(input logic pv, input logic [31:0] pa, input logic st, input logic fl);
      logic ld, nrd;
      logic [15:0] w0;
      ld = 0; nrd = 0;
      if (fl) begin
         e_valid = 0; e_instr = 0; m_busy = 0; m_pend = 0; e_rd = 0;
         return;
      end
      if (m_pend) begin
         if (!st) begin ld = 1; m_pend = 0; m_busy = 0; end
      end else if (m_busy) begin
         if (m_cnt == 2) begin nrd = 1; e_addr = m_pc + 32'd1; end
         m_cnt--;
         if (m_cnt == 0) begin
            if (!st) begin ld = 1; m_busy = 0; end
            else m_pend = 1;
         end
      end else if (pv && !st) begin
         w0 = mem[pa[7:0]];
         m_busy = 1; m_pc = pa; nrd = 1; e_addr = pa;
         m_instr = w0[15] ? {w0, mem[pa[7:0] + 8'd1]} : {16'h0, w0};
         m_cnt = w0[15] ? 2 : 1;
      end
      if (!st) begin
         if (ld) begin e_valid = 1; e_instr = m_instr; e_pc = m_pc; end
         else e_valid = 0;
      end
      e_rd = nrd;
   endtask

   task automatic step(input logic pv, input logic [31:0] pa, input logic st, input logic fl);
      @(negedge clk);
      pc_valid = pv; pc_addr = pa; stall = st; flush = fl;
      #1;
      chk("pc_hold", pc_hold, m_busy || st);
      model_step(pv, pa, st, fl);
      @(posedge clk); #1;
      chk("rd_en", imem_rd_en, e_rd);
      if (e_rd) chk("rd_addr", imem_addr, e_addr);
      chk("if_id_valid", if_id_valid, e_valid);
      chk("if_id_instr", if_id_instr, e_instr);
      chk("if_id_pc", if_id_pc, e_pc);
   endtask

   initial begin
      rst = 1; pc_addr = 0; pc_valid = 0; stall = 0; flush = 0;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[8'h10] = 16'h1234; mem[8'h20] = 16'h8001; mem[8'h21] = 16'hBEEF;
      mem[8'hFF] = 16'h9ABC; mem[8'h00] = 16'h5555;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd_en", imem_rd_en, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_valid", if_id_valid, 0);
      chk("rst_instr", if_id_instr, 0);
      chk("rst_pc", if_id_pc, 0);
      @(negedge clk) rst = 0;

      // short instruction
      step(1, 32'h10, 0, 0);
      chk("short_addr", imem_addr, 32'h10);
      step(0, 0, 0, 0);
      chk("short_instr", if_id_instr, 32'h0000_1234);
      chk("short_valid", if_id_valid, 1);

      // long instruction
      step(1, 32'h20, 0, 0);
      step(0, 0, 0, 0);
      chk("long_addr2", imem_addr, 32'h21);
      step(0, 0, 0, 0);
      chk("long_instr", if_id_instr, 32'h8001_BEEF);
      chk("long_pc", if_id_pc, 32'h20);

      // stall during WORD1 for 3 cycles
      step(1, 32'h20, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      chk("stall_hold_valid", if_id_valid, 0);
      step(0, 0, 0, 0);
      chk("stall_release_instr", if_id_instr, 32'h8001_BEEF);
      chk("stall_release_valid", if_id_valid, 1);

      // flush in WORD0 of a long instruction
      step(1, 32'h20, 0, 0);
      step(0, 0, 0, 1);
      chk("flush_rd_en", imem_rd_en, 0);
      chk("flush_instr", if_id_instr, 0);
      step(1, 32'h10, 0, 0);
      chk("flush_resume_addr", imem_addr, 32'h10);
      step(0, 0, 0, 0);

      // address wrap
      step(1, 32'hFFFF_FFFF, 0, 0);
      step(0, 0, 0, 0);
      chk("wrap_addr2", imem_addr, 32'h0);
      step(0, 0, 0, 0);
      chk("wrap_pc", if_id_pc, 32'hFFFF_FFFF);
      chk("wrap_instr", if_id_instr, 32'h9ABC_5555);

      // async reset in WORD1
      step(1, 32'h20, 0, 0);
      step(0, 0, 0, 0);
      #2 rst = 1;
      #1;
      chk("arst_rd_en", imem_rd_en, 0);
      chk("arst_addr", imem_addr, 0);
      chk("arst_valid", if_id_valid, 0);
      chk("arst_instr", if_id_instr, 0);
      chk("arst_pc", if_id_pc, 0);
      chk("arst_hold", pc_hold, 0);
      model_reset();
      @(negedge clk) rst = 0;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      for (int i = 0; i < 400; i++)
         step($urandom_range(3) != 0, $urandom, $urandom_range(3) == 0, $urandom_range(11) == 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Fetch-stage consumer of the PC circuit's address; reads 16-bit instruction words from a synchronous instruction memory.
- Assembles 16-bit or 32-bit (opcode word + immediate word) instructions and loads them into the IF/ID pipeline register for decode.
- Freezes the PC via pc_hold while a fetch is in flight or decode is stalled; handles flush from branch/hazard logic.

Parameters:
- ADDR_W, 32, width of instruction addresses and of PC values.
- WORD_W, 16, instruction memory word width.
- LONG_BIT, 15, bit of the first word that marks a two-word (32-bit) instruction.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_addr  in  ADDR_W  address from the PC circuit.
- pc_valid  in  1  pc_addr is meaningful this cycle.
- pc_hold  out  1  PC must not advance this cycle (combinational).
- imem_rd_en  out  1  instruction memory read strobe.
- imem_addr  out  ADDR_W  instruction memory read address.
- imem_data  in  WORD_W  read data, valid the cycle after imem_rd_en.
- stall  in  1  decode cannot accept; IF/ID register must hold.
- flush  in  1  discard IF/ID contents and any in-flight fetch.
- if_id_instr  out  2*WORD_W  assembled instruction; a short instruction is zero-extended in the upper half.
- if_id_pc  out  ADDR_W  address of the instruction's first word.
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, takes effect immediately):
  - state=FETCH.
  - imem_rd_en=0, imem_addr=0.
  - if_id_instr=0, if_id_pc=0, if_id_valid=0.
  - Internal lo buffer and cur_pc=0.
- Registered outputs: imem_rd_en, imem_addr, if_id_*.
- pc_hold = (state != FETCH) or stall.
- FETCH:
  - If pc_valid and not stall and not flush: imem_rd_en=1, imem_addr=pc_addr, cur_pc<=pc_addr, go to WORD0.
  - Otherwise imem_rd_en=0 and stay in FETCH.
- WORD0 (first word arrives):
  - lo<=imem_data.
  - If imem_data[LONG_BIT]=1: imem_rd_en=1, imem_addr=cur_pc+1 (mod 2^ADDR_W), go to WORD1.
  - Else the instruction is complete: zero-extended {0, imem_data}.
- WORD1 (second word arrives):
  - Instruction complete: {lo, imem_data}, with the first word in the upper half.
- Completion:
  - If not stall: load IF/ID with instr, if_id_pc=cur_pc, if_id_valid=1; go to FETCH.
  - If stall: buffer the instruction internally and go to PEND.
- PEND: wait while stall=1. On the first cycle with stall=0, load IF/ID from the buffer and go to FETCH.
- IF/ID update rules:
  - Bubble: in any non-stalled cycle with no completion, if_id_valid<=0; if_id_instr and if_id_pc keep their old values.
  - Stall: if_id_* hold all values unchanged, regardless of FSM activity.
- Latency: short instruction reaches IF/ID 2 cycles after its FETCH issue; long instruction after 3 cycles. Peak throughput: one short instruction per 2 cycles.
- Flush (synchronous, priority over stall and completion):
  - if_id_valid<=0, if_id_instr<=0.
  - imem_rd_en<=0; state<=FETCH; a word returning on the next cycle is ignored.
- Stall asserted in the same cycle as the FETCH issue condition: no issue is made.
- An in-flight WORD0 or WORD1 read always completes unless flushed.
- Reset mid-operation: the FSM is aborted, there is no partial IF/ID update, and the unit restarts from FETCH.
- Address wrap: a long instruction at 0xFFFFFFFF reads its second word from 0x00000000.

Decomposition:
- Shared package if_pkg:
  - FSM state enum: FETCH, WORD0, WORD1, PEND.
  - Default widths and LONG_BIT.
  - NOP encoding (0).
- Sub-module if_id_reg: the IF/ID pipeline register with load/stall/flush/async-reset. The fetch FSM stays in if_fetch_unit.

Test Plan:
- Reset then pc_addr=0x10, pc_valid=1, memory[0x10]=0x1234 -> imem_addr=0x10 next cycle; if_id_instr=0x00001234, if_id_pc=0x10, if_id_valid=1 two cycles after issue; pc_hold=1 during WORD0.
- memory[0x20]=0x8001, memory[0x21]=0xBEEF -> second read at 0x21; if_id_instr=0x8001BEEF, if_id_pc=0x20; pc_hold high for 2 cycles.
- Long instruction with stall raised during WORD1 for 3 cycles -> IF/ID holds the previous value throughout; after stall drops, 0x8001BEEF loads on the next edge with valid=1.
- flush asserted in WORD0 of a long instruction -> no second read issued; if_id_valid=0, if_id_instr=0; next FETCH resumes from the current pc_addr.
- Long instruction at pc_addr=0xFFFFFFFF -> second imem_addr=0x00000000; if_id_pc=0xFFFFFFFF.
- rst pulsed asynchronously mid-WORD1 -> all outputs 0 immediately, without a clock edge; no stale instruction appears after reset release.
